// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked RV32I execute ALU with iterative unsigned multiply/divide
// Single-cycle ops complete in one cycle; MUL/MULHU/DIVU/REMU take XLEN cycles.
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    input  logic [3:0]      ALUCtrl_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] data_o,
    output logic            Zero_o,
    output logic            busy_o
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic              op_div_q;
    logic              op_hi_q;
    logic [XLEN-1:0]   opb_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;

    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_res;
    logic              is_iter;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] step_next;
    logic [XLEN-1:0]   iter_res;

    always_comb begin
        shamt   = data2_i[SHW-1:0];
        is_iter = (ALUCtrl_i >= 4'd10) && (ALUCtrl_i <= 4'd13);
        case (ALUCtrl_i)
            4'd0:    alu_res = data1_i + data2_i;
            4'd1:    alu_res = data1_i - data2_i;
            4'd2:    alu_res = data1_i << shamt;
            4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(data1_i) < $signed(data2_i)};
            4'd4:    alu_res = {{(XLEN-1){1'b0}}, data1_i < data2_i};
            4'd5:    alu_res = data1_i ^ data2_i;
            4'd6:    alu_res = data1_i >> shamt;
            4'd7:    alu_res = $signed(data1_i) >>> shamt;
            4'd8:    alu_res = data1_i | data2_i;
            4'd9:    alu_res = data1_i & data2_i;
            default: alu_res = data1_i;
        endcase
    end

    // acc_q is {high, low}: product/multiplier for MUL, remainder/quotient for DIV.
    // A zero divisor never underflows, giving quotient all-ones and remainder = dividend.
    always_comb begin
        add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opb_q};
        if (!op_div_q)
            step_next = {add_sum, acc_q[XLEN-1:1]};
        else if (div_diff[XLEN])
            step_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            step_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        iter_res = op_hi_q ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            busy_o   <= 1'b0;
            data_o   <= '0;
            Zero_o   <= 1'b1;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            op_hi_q  <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        ready_o <= 1'b0;
                        if (is_iter) begin
                            op_div_q <= ALUCtrl_i[2];
                            op_hi_q  <= ALUCtrl_i[0];
                            opb_q    <= data2_i;
                            acc_q    <= {{XLEN{1'b0}}, data1_i};
                            cnt_q    <= CW'(XLEN);
                            busy_o   <= 1'b1;
                            state    <= CALC;
                        end else begin
                            data_o  <= alu_res;
                            Zero_o  <= (alu_res == '0);
                            valid_o <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                CALC: begin
                    acc_q <= step_next;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        data_o  <= iter_res;
                        Zero_o  <= (iter_res == '0);
                        valid_o <= 1'b1;
                        busy_o  <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
